pio_edge_irq_ctrl: RTL and testbench



---
 rtl/pio_ctrl_pkg.sv | 18 +
 rtl/pio_debounce_bit.sv | 83 ++++++++
 rtl/pio_edge_irq_ctrl.sv | 128 ++++++++++++
 tb/tb_pio_edge_irq_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_ctrl_pkg.sv
// Shared constants and types for the PIO edge-interrupt controller.
package pio_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_EDGE   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } deb_state_t;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: 2-flop synchroniser followed by an optional debounce FSM.
// The debounce FSM and its counter exist only when PIO_DEBOUNCE_EN is defined.
module pio_debounce_bit
    import pio_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pin,
`ifdef PIO_DEBOUNCE_EN
    input  logic [CNT_W-1:0] period,
`endif
    output logic             deb
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    deb_state_t       state;
    deb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             deb_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            deb   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            deb   <= deb_next;
        end
    end

    // A mismatch must persist for period compares; any return to deb aborts.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        deb_next   = deb;
        case (state)
            IDLE: begin
                if (sync2 != deb) begin
                    state_next = COUNT;
                    cnt_next   = CNT_W'(1);
                end
            end
            COUNT: begin
                if (sync2 == deb) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt >= period) begin
                    deb_next   = sync2;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt != {CNT_W{1'b1}}) begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
        endcase
    end
`else
    assign deb = sync2;

    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("pio_debounce_bit: CNT_W must be non-zero");
    end
`endif

endmodule

// File: rtl/pio_edge_irq_ctrl.sv
// Avalon-MM PIO input port with per-bit debounce, sticky edge capture and masked irq.
// Optional debounce counters and the period register are enabled by PIO_DEBOUNCE_EN.
module pio_edge_irq_ctrl
    import pio_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DEBOUNCE_RST = 1000,
    parameter int unsigned EDGE_MODE    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32 || CNT_W < 1 || CNT_W > 32 ||
        64'(DEBOUNCE_RST) >= (64'd1 << CNT_W)) begin : g_param_check
        $error("pio_edge_irq_ctrl: parameter out of range");
    end

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_next;
    logic             irq_next;
    logic             wr_en;
`ifdef PIO_DEBOUNCE_EN
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] period_next;
`endif

    // Read strobe is not needed (readdata tracks address every cycle); upper write bits are ignored.
    logic unused_bus;
    assign unused_bus = &{1'b0, read, writedata};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .CNT_W (CNT_W)
        ) u_bit (
            .clk    (clk),
            .rst    (reset),
            .pin    (in_port[i]),
`ifdef PIO_DEBOUNCE_EN
            .period (period),
`endif
            .deb    (deb[i])
        );
    end

    always_comb begin
        rise = deb & ~deb_d;
        fall = ~deb & deb_d;
        case (EDGE_MODE)
            EDGE_RISE: det = rise;
            EDGE_FALL: det = fall;
            default:   det = rise | fall;
        endcase
    end

    // Register next-state; a newly detected edge overrides a same-cycle clear.
    always_comb begin
        wr_en     = chipselect & ~write_n;
        mask_next = mask;
        clr       = '0;
        if (wr_en && address == ADDR_MASK) mask_next = writedata[WIDTH-1:0];
        if (wr_en && address == ADDR_EDGE) clr = writedata[WIDTH-1:0];
        edge_next = (edge_cap & ~clr) | det;
        irq_next  = |(edge_next & mask_next);
`ifdef PIO_DEBOUNCE_EN
        period_next = period;
        if (wr_en && address == ADDR_PERIOD) period_next = writedata[CNT_W-1:0];
`endif
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:   rd_next = 32'(deb);
            ADDR_MASK:   rd_next = 32'(mask);
            ADDR_EDGE:   rd_next = 32'(edge_cap);
            ADDR_PERIOD: begin
`ifdef PIO_DEBOUNCE_EN
                rd_next = 32'(period);
`else
                rd_next = '0;
`endif
            end
        endcase
    end

    // irq is registered from next-state so it equals |(edge_cap & mask) without glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            irq      <= 1'b0;
            mask     <= '0;
            edge_cap <= '0;
            deb_d    <= '0;
`ifdef PIO_DEBOUNCE_EN
            period   <= CNT_W'(DEBOUNCE_RST);
`endif
        end else begin
            readdata <= rd_next;
            irq      <= irq_next;
            mask     <= mask_next;
            edge_cap <= edge_next;
            deb_d    <= deb;
`ifdef PIO_DEBOUNCE_EN
            period   <= period_next;
`endif
        end
    end

endmodule

// File: tb/tb_pio_edge_irq_ctrl.sv
// Self-checking bench for pio_edge_irq_ctrl; adapts expectations to PIO_DEBOUNCE_EN.
module tb_pio_edge_irq_ctrl;

`ifdef PIO_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif
    localparam logic [31:0] PRD_RB    = DEB_ON ? 32'd2 : 32'd0;
    localparam logic [31:0] RST_PRD   = DEB_ON ? 32'd1000 : 32'd0;
    localparam logic [31:0] GLITCH_EC = DEB_ON ? 32'd0 : 32'd2;
    // Edge after the pin change where deb rises (period 4 when debounce is on).
    localparam int          LAT       = DEB_ON ? (3 + 4) : 2;
    localparam int          NVEC      = 15;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [3:0]  pins;
        logic        do_wr;
        logic        cs;
        logic [1:0]  addr;
        logic [31:0] wdata;
        int          settle;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[NVEC];

    pio_edge_irq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic cs_v);
        address    = a;
        writedata  = d;
        chipselect = cs_v;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        cyc();
        d          = readdata;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          first_irq;
        int          first_rd;

        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        read       = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'h0;
        repeat (3) cyc();
        check("por_readdata", readdata, 32'd0);
        check("por_irq", 32'(irq), 32'd0);
        reset = 1'b0;

        // {pins, do_wr, cs, addr, wdata, settle, exp_rd, exp_irq}
        vecs[0]  = '{4'h0, 1'b1, 1'b1, 2'd3, 32'd2,         0, PRD_RB, 1'b0};
        vecs[1]  = '{4'h0, 1'b1, 1'b1, 2'd1, 32'hFFFF_FFF5, 0, 32'h5,  1'b0};
        vecs[2]  = '{4'h1, 1'b0, 1'b0, 2'd0, 32'd0,         8, 32'h1,  1'b1};
        vecs[3]  = '{4'h1, 1'b0, 1'b0, 2'd2, 32'd0,         0, 32'h1,  1'b1};
        vecs[4]  = '{4'h3, 1'b0, 1'b0, 2'd2, 32'd0,         8, 32'h3,  1'b1};
        vecs[5]  = '{4'h3, 1'b1, 1'b1, 2'd2, 32'h1,         0, 32'h2,  1'b0};
        vecs[6]  = '{4'h3, 1'b1, 1'b1, 2'd1, 32'h2,         0, 32'h2,  1'b1};
        vecs[7]  = '{4'h0, 1'b0, 1'b0, 2'd2, 32'd0,         8, 32'h2,  1'b1};
        vecs[8]  = '{4'h0, 1'b1, 1'b1, 2'd2, 32'hF,         0, 32'h0,  1'b0};
        vecs[9]  = '{4'hC, 1'b0, 1'b0, 2'd0, 32'd0,         8, 32'hC,  1'b0};
        vecs[10] = '{4'hC, 1'b0, 1'b0, 2'd2, 32'd0,         0, 32'hC,  1'b0};
        vecs[11] = '{4'hC, 1'b1, 1'b1, 2'd1, 32'h4,         0, 32'h4,  1'b1};
        vecs[12] = '{4'hC, 1'b1, 1'b1, 2'd2, 32'h4,         0, 32'h8,  1'b0};
        vecs[13] = '{4'hC, 1'b1, 1'b0, 2'd1, 32'hF,         0, 32'h4,  1'b0};
        vecs[14] = '{4'hC, 1'b1, 1'b1, 2'd2, 32'hF,         0, 32'h0,  1'b0};

        for (int i = 0; i < NVEC; i++) begin
            in_port = vecs[i].pins;
            if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata, vecs[i].cs);
            repeat (vecs[i].settle) cyc();
            rd(vecs[i].addr, d);
            check($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end

        // Exact pin-to-capture latency on a clean rising edge.
        in_port = 4'h0;
        repeat (15) cyc();
        wr(2'd1, 32'h1, 1'b1);
        wr(2'd2, 32'hF, 1'b1);
`ifdef PIO_DEBOUNCE_EN
        wr(2'd3, 32'd4, 1'b1);
`endif
        address   = 2'd0;
        in_port   = 4'h1;
        first_irq = 0;
        first_rd  = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (first_irq == 0 && irq) first_irq = k;
            if (first_rd == 0 && readdata[0]) first_rd = k;
            if (first_irq != 0 && first_rd != 0) break;
        end
        check("lat_deb", 32'(first_rd), 32'(LAT + 1));
        check("lat_irq", 32'(first_irq), 32'(LAT + 1));
        rd(2'd2, d);
        check("clean_edge", d, 32'h1);
        wr(2'd2, 32'h1, 1'b1);
        check("w1c_irq", 32'(irq), 32'd0);
        rd(2'd2, d);
        check("w1c_edge", d, 32'h0);

        // Short pulse on bit 1: rejected by debounce, captured without it.
`ifdef PIO_DEBOUNCE_EN
        wr(2'd3, 32'd8, 1'b1);
        in_port = 4'h3;
        repeat (5) cyc();
        in_port = 4'h1;
`else
        in_port = 4'h3;
        cyc();
        in_port = 4'h1;
`endif
        repeat (20) cyc();
        rd(2'd0, d);
        check("glitch_data", d, 32'h1);
        rd(2'd2, d);
        check("glitch_edge", d, GLITCH_EC);
        check("glitch_irq", 32'(irq), 32'd0);
        wr(2'd2, 32'hF, 1'b1);

        // Clear of bit 3 lands on the same edge as a new bit-3 capture.
`ifdef PIO_DEBOUNCE_EN
        wr(2'd3, 32'd4, 1'b1);
`endif
        wr(2'd1, 32'h8, 1'b1);
        in_port = 4'h9;
        repeat (15) cyc();
        rd(2'd2, d);
        check("coll_pre", d, 32'h8);
        in_port = 4'h1;
        repeat (15) cyc();
        rd(2'd2, d);
        check("fall_ignored", d, 32'h8);
        in_port = 4'h9;
        repeat (LAT) cyc();
        wr(2'd2, 32'h8, 1'b1);
        check("coll_irq", 32'(irq), 32'd1);
        rd(2'd2, d);
        check("coll_set_wins", d, 32'h8);
        wr(2'd2, 32'h8, 1'b1);
        rd(2'd2, d);
        check("coll_clear", d, 32'h0);
        check("coll_clear_irq", 32'(irq), 32'd0);

        // Reset mid-run with all pins high.
        in_port = 4'hF;
        wr(2'd1, 32'hF, 1'b1);
        repeat (4) cyc();
        reset = 1'b1;
        #2;
        check("rst_async_rd", readdata, 32'd0);
        check("rst_async_irq", 32'(irq), 32'd0);
        repeat (2) cyc();
        reset = 1'b0;
        rd(2'd2, d);
        check("rst_edge0", d, 32'h0);
        rd(2'd1, d);
        check("rst_mask", d, 32'h0);
        rd(2'd3, d);
        check("rst_period", d, RST_PRD);
        for (int k = 0; k < 1200; k++) begin
            rd(2'd2, d);
            if (d == 32'hF) break;
        end
        check("rst_held_edges", d, 32'hF);
        check("rst_held_irq", 32'(irq), 32'd0);
        wr(2'd1, 32'hF, 1'b1);
        check("rst_unmask_irq", 32'(irq), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
